// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
//
// Purpose:
//   32 x 32-bit processor register file. It sits directly behind a 5-to-32
//   write decoder, so each register's write strobe is one line of the one-hot
//   bus wsel_onehot. It has two combinational read ports indexed by 5-bit
//   register numbers, and register 0 always reads as zero. A sticky flag
//   records any qualified write whose select was not exactly one-hot.
//
// Parameters:
//   WIDTH   data width of each register
//   NREGS   number of registers; equals the decoder bus width (32 for 5-bit
//           read indices)
//   BYPASS  1: a read of the register being written this cycle returns
//              data_writeReg
//           0: the read returns the stored value
//
// Ports:
//   clock             in   rising-edge clock
//   reset             in   synchronous active-high reset
//   ctrl_writeEnable  in   global write qualifier
//   wsel_onehot       in   one-hot register select (bit i selects register i)
//   data_writeReg     in   write data
//   ctrl_readRegA     in   read port A index
//   ctrl_readRegB     in   read port B index
//   data_readRegA     out  read port A data (combinational)
//   data_readRegB     out  read port B data (combinational)
//   onehot_err        out  sticky malformed-select flag, cleared only by reset
// -----------------------------------------------------------------------------
module regfile_onehot_wr #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_writeEnable,
    input  logic [NREGS-1:0] wsel_onehot,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    output logic             onehot_err
);

    logic [WIDTH-1:0] r_regs [0:NREGS-1];
    logic             r_onehot_err;

    logic             w_sel_nonzero;
    logic             w_sel_multi;
    logic             w_sel_onehot;
    logic             w_wr_valid;
    logic [NREGS-1:0] w_we;

    // Exactly one bit set <=> nonzero and clearing the lowest set bit
    // leaves nothing behind.
    assign w_sel_nonzero = |wsel_onehot;
    assign w_sel_multi   = |(wsel_onehot & (wsel_onehot - {{(NREGS-1){1'b0}}, 1'b1}));
    assign w_sel_onehot  = w_sel_nonzero & ~w_sel_multi;

    // Reset also gates the write here. The stored state would ignore the
    // write anyway, but the bypass path must not forward it.
    assign w_wr_valid    = ctrl_writeEnable & w_sel_onehot & ~reset;

    // Per-register write strobes. Register 0 never gets a strobe, so a
    // write aimed at it is accepted but has no effect.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : gen_we
            if (gi == 0) begin : g_zero
                assign w_we[gi] = 1'b0;
            end else begin : g_reg
                assign w_we[gi] = w_wr_valid & wsel_onehot[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_onehot_err <= 1'b0;
        end else begin
            // With the write qualifier low, the select bus is ignored entirely.
            if (ctrl_writeEnable && !w_sel_onehot) begin
                r_onehot_err <= 1'b1;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= data_writeReg;
                end
            end
        end
    end

    // Two identical read ports: port 0 serves A and port 1 serves B.
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_rd
            logic [4:0]       w_raddr;
            logic [WIDTH-1:0] w_rdata;

            assign w_raddr = (gi == 0) ? ctrl_readRegA : ctrl_readRegB;

            always_comb begin
                w_rdata = '0;
                if (!reset && (w_raddr != 5'd0)) begin
                    // w_we[0] is always low, so the bypass cannot expose
                    // register 0.
                    if ((BYPASS != 0) && w_we[w_raddr]) begin
                        w_rdata = data_writeReg;
                    end else begin
                        w_rdata = r_regs[w_raddr];
                    end
                end
            end
        end
    endgenerate

    assign data_readRegA = gen_rd[0].w_rdata;
    assign data_readRegB = gen_rd[1].w_rdata;
    assign onehot_err    = r_onehot_err;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
module tb_regfile_onehot_wr;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [31:0] wsel;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] a_byp, b_byp, a_nb, b_nb;
    logic        err_byp, err_nb;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored contents plus the sticky flag.
    logic [31:0] m_regs [32];
    logic        m_err;

    regfile_onehot_wr #(.WIDTH(32), .NREGS(32), .BYPASS(1)) dut (
        .clock(clk), .reset(rst), .ctrl_writeEnable(wen), .wsel_onehot(wsel),
        .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a_byp), .data_readRegB(b_byp), .onehot_err(err_byp)
    );

    regfile_onehot_wr #(.WIDTH(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clock(clk), .reset(rst), .ctrl_writeEnable(wen), .wsel_onehot(wsel),
        .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a_nb), .data_readRegB(b_nb), .onehot_err(err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then let the combinational reads settle.
    task automatic apply(input logic r, input logic we, input logic [31:0] sel,
                         input logic [31:0] d, input logic [4:0] xa, input logic [4:0] xb);
        rst = r; wen = we; wsel = sel; wdata = d; ra = xa; rb = xb;
        #1;
    endtask

    // Clock edge: the model takes the same edge as the DUT, then the bench
    // waits for the falling edge before driving the next cycle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_err = 1'b0;
        end else if (wen) begin
            if ($countones(wsel) == 1) begin
                for (int i = 1; i < 32; i++) if (wsel[i]) m_regs[i] = wdata;
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] idx, input bit byp);
        if (rst || idx == 5'd0) return '0;
        if (byp && wen && $countones(wsel) == 1 && wsel[idx]) return wdata;
        return m_regs[idx];
    endfunction

    typedef struct {
        logic        r;
        logic        we;
        logic [31:0] sel;
        logic [31:0] d;
        logic [4:0]  xa;
        logic [4:0]  xb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eerr;
    } vec_t;

    vec_t vt [14];

    initial begin
        // Expected values for the BYPASS=1 instance, sampled before each edge.
        vt[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 5'd3,  5'd0,  32'hDEAD_BEEF, 32'h0,          1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 5'd3,  5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h1234_5678, 5'd0,  5'd0,  32'h0,          32'h0,          1'b0};
        vt[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         5'd31, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         5'd7,  5'd1,  32'hA5A5_A5A5, 32'h0,          1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 5'd1,  5'd2,  32'h0,          32'h0,          1'b0};
        vt[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 5'd1,  5'd2,  32'h0,          32'h0,          1'b1};
        vt[8]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_0011, 5'd9,  5'd7,  32'h0000_0011, 32'hA5A5_A5A5, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         5'd9,  5'd3,  32'h0000_0011, 32'hDEAD_BEEF, 1'b1};
        vt[10] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0055, 5'd9,  5'd3,  32'h0,          32'h0,          1'b1};
        vt[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         5'd9,  5'd31, 32'h0,          32'h0,          1'b0};
        vt[12] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         5'd7,  5'd3,  32'h0,          32'h0,          1'b0};
        vt[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         5'd0,  5'd0,  32'h0,          32'h0,          1'b0};

        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_err = 1'b0;
        rst = 1'b1; wen = 1'b0; wsel = '0; wdata = '0; ra = '0; rb = '0;
        @(negedge clk);

        // One reset cycle, then every index reads zero on both ports.
        apply(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            check($sformatf("post_reset_a[%0d]", i), a_byp, 32'h0);
            check($sformatf("post_reset_b[%0d]", 31 - i), b_byp, 32'h0);
            tick();
        end
        check("post_reset_err", {31'h0, err_byp}, 32'h0);

        // Table of directed vectors.
        for (int v = 0; v < 14; v++) begin
            apply(vt[v].r, vt[v].we, vt[v].sel, vt[v].d, vt[v].xa, vt[v].xb);
            check($sformatf("vec%0d_a", v), a_byp, vt[v].ea);
            check($sformatf("vec%0d_b", v), b_byp, vt[v].eb);
            check($sformatf("vec%0d_err", v), {31'h0, err_byp}, {31'h0, vt[v].eerr});
            check($sformatf("vec%0d_err_nb", v), {31'h0, err_nb}, {31'h0, vt[v].eerr});
            tick();
        end

        // Same-cycle write and read of reg 7: forwarded vs stored value.
        apply(1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd7, 5'd7);
        check("byp1_same_cycle_b", b_byp, 32'hA5A5_A5A5);
        check("byp0_same_cycle_b", b_nb, 32'h0);
        check("byp0_same_cycle_a", a_nb, 32'h0);
        tick();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7);
        check("byp0_next_cycle_b", b_nb, 32'hA5A5_A5A5);
        tick();

        // 32 back-to-back writes of i to reg i.
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b1, 32'h1 << i, 32'(i), 5'(i), (i == 0) ? 5'd0 : 5'(i - 1));
            check($sformatf("b2b_byp_a[%0d]", i), a_byp, 32'(i));
            check($sformatf("b2b_prev_b[%0d]", i), b_byp, (i == 0) ? 32'h0 : 32'(i - 1));
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            check($sformatf("b2b_read_a[%0d]", i), a_byp, 32'(i));
            check($sformatf("b2b_read_b_nb[%0d]", 31 - i), b_nb, 32'(31 - i));
            tick();
        end
        check("b2b_err", {31'h0, err_byp}, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] s;
            logic [4:0]  xa, xb;
            int          a, b;
            case ($urandom_range(0, 9))
                0: s = 32'h0;
                1: begin
                    a = $urandom_range(0, 31);
                    b = (a + 1 + $urandom_range(0, 30)) % 32;
                    s = (32'h1 << a) | (32'h1 << b);
                end
                2: s = 32'hFFFF_FFFF;
                default: s = 32'h1 << $urandom_range(0, 31);
            endcase
            xa = 5'($urandom_range(0, 31));
            xb = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 32; k++) if (s[k]) xa = 5'(k);
            end
            if ($urandom_range(0, 3) == 0) xb = xa;
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), s, $urandom, xa, xb);
            check("rnd_a_byp", a_byp, model_rd(ra, 1'b1));
            check("rnd_b_byp", b_byp, model_rd(rb, 1'b1));
            check("rnd_a_nb", a_nb, model_rd(ra, 1'b0));
            check("rnd_b_nb", b_nb, model_rd(rb, 1'b0));
            check("rnd_err", {31'h0, err_byp}, {31'h0, m_err});
            check("rnd_err_nb", {31'h0, err_nb}, {31'h0, m_err});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
